// File: rtl/tpg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tpg_arbiter
// Description : Round-robin arbiter sharing one router ingress port among K
//               traffic generators. One grant per cycle into a registered
//               valid/ready output stage, with saturating per-requester
//               accepted-word counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tpg_arbiter #(
    parameter int WIDTH     = 32,
    parameter int K         = 4,
    parameter int K_WIDTH   = $clog2(K),
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [K*WIDTH-1:0]     data_in,
    input  logic [K-1:0]           valid_in,
    output logic [K-1:0]           ready_out,
    output logic [WIDTH-1:0]       data_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [K*CNT_WIDTH-1:0] grant_cnt,
    output logic [K_WIDTH-1:0]     last_grant
);

    // Output register occupancy
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    // Requester count and last index in pointer-compatible widths
    localparam logic [K_WIDTH:0]   K_EXT    = (K_WIDTH + 1)'(K);
    localparam logic [K_WIDTH-1:0] LAST_IDX = K_WIDTH'(K - 1);

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic               load;
    logic               found;
    logic               grant;
    logic [K_WIDTH-1:0] ptr;
    logic [K_WIDTH-1:0] winner;
    logic [K_WIDTH:0]   cand;

    // The output register may take a new word when it is empty or being drained
    assign load  = enable & (~valid_out | ready_in);
    assign grant = load & found;

    // Round-robin search starting at ptr, wrapping from K-1 back to 0
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int off = 0; off < K; off++) begin
            cand = {1'b0, ptr} + (K_WIDTH + 1)'(off);
            if (cand >= K_EXT) begin
                cand = cand - K_EXT;
            end
            if (!found && valid_in[cand[K_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = cand[K_WIDTH-1:0];
            end
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A grant fills the register; otherwise an accepted word empties it
    always_comb begin
        state_next = state;
        if (grant) begin
            state_next = FULL;
        end else if (ready_in) begin
            state_next = EMPTY;
        end
    end

    // Occupancy flag and one-hot handshake back to the winning requester
    always_comb begin
        valid_out = (state == FULL);
        ready_out = '0;
        if (grant && !rst) begin
            ready_out[winner] = 1'b1;
        end
    end

    // Capture the winning word and advance the round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            ptr        <= '0;
            last_grant <= '0;
        end else if (grant) begin
            data_out   <= data_in[winner*WIDTH +: WIDTH];
            ptr        <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
            last_grant <= winner;
        end
    end

    // Per-requester saturating counters of accepted words
    for (genvar i = 0; i < K; i++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt;

        // Count grants to this requester, sticking at all-ones
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (grant && (winner == K_WIDTH'(i)) && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_tpg_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tpg_arbiter
// Description : Self-checking bench for tpg_arbiter: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpg_arbiter;

    localparam int WIDTH     = 32;
    localparam int K         = 4;
    localparam int K_WIDTH   = $clog2(K);
    localparam int CNT_WIDTH = 4;
    localparam int CMAX      = (1 << CNT_WIDTH) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   enable;
    logic [K*WIDTH-1:0]     data_in;
    logic [K-1:0]           valid_in;
    logic [K-1:0]           ready_out;
    logic [WIDTH-1:0]       data_out;
    logic                   valid_out;
    logic                   ready_in;
    logic [K*CNT_WIDTH-1:0] grant_cnt;
    logic [K_WIDTH-1:0]     last_grant;

    tpg_arbiter #(
        .WIDTH     (WIDTH),
        .K         (K),
        .K_WIDTH   (K_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .grant_cnt  (grant_cnt),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Behavioural model state
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_ptr;
    int               m_last;
    int               m_cnt [K];
    logic [K-1:0]     last_acc;
    int               snap [K];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [K-1:0] v, input int p);
        for (int j = 0; j < K; j++) begin
            if (v[(p + j) % K]) return (p + j) % K;
        end
        return -1;
    endfunction

    function automatic logic [K*CNT_WIDTH-1:0] exp_cnt();
        logic [K*CNT_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < K; i++) r[i*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(m_cnt[i]);
        return r;
    endfunction

    function automatic int dut_cnt(input int i);
        return int'(grant_cnt[i*CNT_WIDTH +: CNT_WIDTH]);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ptr   = 0;
        m_last  = 0;
        for (int i = 0; i < K; i++) m_cnt[i] = 0;
    endtask

    task automatic set_port(input int i, input logic [WIDTH-1:0] d);
        data_in[i*WIDTH +: WIDTH] = d;
    endtask

    // One clock cycle: check handshake before the edge, model the edge, check outputs after
    task automatic step();
        int           w;
        logic         ld;
        logic [K-1:0] er;
        w  = pick(valid_in, m_ptr);
        ld = enable && (!m_valid || ready_in);
        er = '0;
        if (ld && w >= 0) er[w] = 1'b1;
        #1 check("ready_out", 64'(ready_out), 64'(er));
        @(posedge clk);
        if (ld) begin
            if (w >= 0) begin
                m_data  = data_in[w*WIDTH +: WIDTH];
                m_valid = 1'b1;
                m_ptr   = (w + 1) % K;
                m_last  = w;
                if (m_cnt[w] < CMAX) m_cnt[w]++;
            end else begin
                m_valid = 1'b0;
            end
        end else if (ready_in && m_valid) begin
            m_valid = 1'b0;
        end
        last_acc = er & valid_in;
        #1;
        check("valid_out", 64'(valid_out), 64'(m_valid));
        check("data_out", 64'(data_out), 64'(m_data));
        check("last_grant", 64'(last_grant), 64'(m_last));
        check("grant_cnt", 64'(grant_cnt), 64'(exp_cnt()));
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        ready_in = 1'b1;
        valid_in = 4'b1111;
        data_in  = '0;
        model_reset();
        #12;
        // Reset state, with requests present to show ready_out is held off
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_last_grant", 64'(last_grant), 64'd0);
        check("rst_grant_cnt", 64'(grant_cnt), 64'd0);
        check("rst_ready_out", 64'(ready_out), 64'd0);
        rst = 1'b0;

        // Full rotation: four requesters continuously active
        for (int i = 0; i < K; i++) set_port(i, 32'hA000_0000 + 32'(i));
        for (int k = 0; k < 8; k++) begin
            step();
            check("rot_data", 64'(data_out), 64'(32'hA000_0000 + 32'(k % K)));
        end
        for (int i = 0; i < K; i++) check("rot_cnt", 64'(dut_cnt(i)), 64'd2);

        // Back-pressure: hold a word while the router stalls
        valid_in = 4'b0001;
        set_port(0, 32'h3C00_0007);
        step();
        check("bp_load", 64'(data_out), 64'h3C00_0007);
        valid_in = 4'b1111;
        set_port(0, 32'h1111_0000);
        ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold", 64'(data_out), 64'h3C00_0007);
            check("bp_ready", 64'(last_acc), 64'd0);
        end
        ready_in = 1'b1;
        step();
        check("bp_nobubble_grant", 64'(last_grant), 64'd1);
        check("bp_nobubble_data", 64'(data_out), 64'(32'hA000_0001));

        // Sparse requests after moving the pointer to 1
        valid_in = 4'b0001;
        step();
        valid_in = 4'b1001;
        step();
        check("sparse_1", 64'(last_grant), 64'd3);
        step();
        check("sparse_2", 64'(last_grant), 64'd0);
        step();
        check("sparse_3", 64'(last_grant), 64'd3);

        // Enable low: pending word drains, nothing new granted
        for (int i = 0; i < K; i++) snap[i] = dut_cnt(i);
        enable   = 1'b0;
        valid_in = 4'b1111;
        step();
        check("en_drain", 64'(valid_out), 64'd0);
        step();
        for (int i = 0; i < K; i++) check("en_frozen", 64'(dut_cnt(i)), 64'(snap[i]));
        enable = 1'b1;

        // Saturation of one counter
        for (int i = 0; i < K; i++) snap[i] = dut_cnt(i);
        valid_in = 4'b0100;
        for (int k = 0; k < 20; k++) step();
        check("sat_cnt2", 64'(dut_cnt(2)), 64'(CMAX));
        for (int i = 0; i < K; i++) begin
            if (i != 2) check("sat_others", 64'(dut_cnt(i)), 64'(snap[i]));
        end

        // Asynchronous reset mid-cycle with a word pending
        valid_in = 4'b0001;
        step();
        check("pre_rst_valid", 64'(valid_out), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_valid_out", 64'(valid_out), 64'd0);
        check("arst_grant_cnt", 64'(grant_cnt), 64'd0);
        check("arst_ready_out", 64'(ready_out), 64'd0);
        model_reset();
        #10 rst = 1'b0;
        valid_in = 4'b1010;
        set_port(1, 32'h0102_0304);
        set_port(3, 32'h0506_0708);
        step();
        check("arst_first_grant", 64'(last_grant), 64'd1);
        check("arst_first_data", 64'(data_out), 64'h0102_0304);

        // Randomized traffic honouring the hold-until-accepted rule
        last_acc = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < K; i++) begin
                if (last_acc[i] || !valid_in[i]) begin
                    valid_in[i] = ($urandom_range(0, 2) != 0);
                    set_port(i, $urandom);
                end
            end
            enable   = ($urandom_range(0, 9) != 0);
            ready_in = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tpg_arbiter.md
# tpg_arbiter

Round-robin arbiter that shares one NoC router ingress port among `K` traffic generators. Each generator presents single-word packets in the standard packet format: src, dst, 8-bit id, then a data counter, MSB first. The block grants one requester per cycle into a registered output stage with valid/ready flow control. It keeps saturating per-requester grant counters for traffic analysis. It sits between the TPG array and a router ingress port, on the sending side of the packet analyzers.

## Interface
Parameters:
- `WIDTH`, 32: packet word width.
- `K`, 4: number of requesters; K ≥ 2.
- `K_WIDTH`, `$clog2(K)`: pointer and index width.
- `CNT_WIDTH`, 16: width of each grant counter.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: when 0, no new grants are issued; the output stage still drains.
- `data_in`, input, K*WIDTH: requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `valid_in`, input, K: per-requester request.
- `ready_out`, output, K: one-hot or zero; requester i's word is accepted this cycle iff `valid_in[i] & ready_out[i]`.
- `data_out`, output, WIDTH: registered packet word to the router.
- `valid_out`, output, 1: registered; `data_out` is valid.
- `ready_in`, input, 1: router accepts the word this cycle when `valid_out & ready_in`.
- `grant_cnt`, output, K*CNT_WIDTH: per-requester accepted-word counters, requester i at `[i*CNT_WIDTH +: CNT_WIDTH]`.
- `last_grant`, output, K_WIDTH: index of the most recently granted requester.

## Operation
- **Output register states:**
  - EMPTY: `valid_out` = 0.
  - FULL: `valid_out` = 1.
- **Load enable:** `load = enable & (~valid_out | ready_in)`. This is combinational and allows full-throughput pass-through.
- **Arbitration:**
  - Combinational round-robin over `valid_in`, searching from pointer `ptr` upward, wrapping from K-1 to 0.
  - The winner is the first index with `valid_in` set.
  - `ready_out = load ? onehot(winner) : 0`. It is 0 when no request is present.
- **On a grant** (load and any valid):
  - `data_out` ← `data_in[winner]`.
  - `valid_out` ← 1.
  - `ptr` ← (winner+1) mod K, wrapping correctly for non-power-of-2 K.
  - `last_grant` ← winner.
  - `grant_cnt[winner]` increments, saturating at all-ones.
- **On load with no request:** `valid_out` ← 0; `data_out` holds its last value; `ptr` is unchanged.
- **When load = 0:** `valid_out`, `data_out` and `ptr` hold.
  - If `enable` = 0 and `ready_in` = 1 with `valid_out` = 1, the word is consumed and `valid_out` ← 0.
- **Content:** the packet word passes unmodified; src, dst, id and data are not interpreted.
- **Ready independence:** `ready_out` never depends on `valid_in[i]` of the same index other than through winner selection. A requester must not deassert `valid_in` or change `data_in` until accepted.

## Timing
- **Reset values:** `valid_out` 0, `data_out` 0, `ptr` 0, `last_grant` 0, all `grant_cnt` 0. `ready_out` is 0 while `rst` is asserted.
- **Latency:** a word accepted in cycle t is visible on `data_out` with `valid_out` = 1 in cycle t+1.
- **Throughput:** 1 word/cycle when `ready_in` is held high and requests are present.
- **Back-pressure:** with `valid_out` = 1 and `ready_in` = 0, `data_out` is held stable and all `ready_out` are 0.
- **Simultaneous drain and load:** same cycle, no bubble.
- **Fairness:** with all K requesting continuously and `ready_in` = 1, the grant order is ptr, ptr+1, …, with each requester granted exactly once per K cycles.
- **Reset mid-operation:** the pending output word is discarded; the first grant after reset goes to the lowest-index active requester.
- **Counter saturation:** a counter at 2^CNT_WIDTH−1 stays there; other counters are unaffected.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle with `valid_out` = 1. Required: `valid_out` drops immediately, all counters 0; after release with `valid_in` = 4'b1010, the first grant goes to index 1.
- **Full rotation:** K=4, all `valid_in` high, `ready_in` = 1, 8 cycles, distinct `data_in` per port. Required: `data_out` sequence port 0,1,2,3,0,1,2,3 starting 1 cycle after the first grant; each `grant_cnt` = 2.
- **Back-pressure:** `ready_in` = 0 for 5 cycles with `valid_out` = 1 and data 0x3C00_0007. Required: `data_out` stable, `ready_out` = 0; on `ready_in` = 1, the next grant occurs in the same cycle with no bubble.
- **Sparse requests:** `valid_in` = 4'b1001 after ptr=1. Required: grant to 3, then 0, then 3.
- **Enable low:** `enable` = 0 with a pending output word and `ready_in` = 1. Required: the word drains, `valid_out` = 0 next cycle, no `ready_out` asserted, counters frozen.
- **Saturation:** CNT_WIDTH=4, 20 grants to port 2. Required: `grant_cnt[2]` = 15, others unchanged.
